// File: rtl/cvxif_router_pkg.sv
// Shared types and helpers for the CV-X-IF coprocessor router.
package cvxif_router_pkg;

    localparam int unsigned MAX_COPRO = 8;
    localparam int unsigned OWNER_W   = 3;
    localparam int unsigned EXCCODE_W = 6;

    // Sized for the largest supported fan-out; unused upper mask bits stay zero.
    typedef struct packed {
        logic                 valid;
        logic [OWNER_W-1:0]   owner;
        logic [MAX_COPRO-1:0] mask;
        logic                 wb;
        logic                 committed;
    } entry_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer moves past the grantee.
module rr_arbiter
    import cvxif_router_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int unsigned PW = idx_w(NUM_REQ);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   idx;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_i[PW'(idx)]) begin
                found            = 1'b1;
                gnt_o[PW'(idx)]  = 1'b1;
                ptr_d            = (idx + 1 == NUM_REQ) ? '0 : PW'(idx + 1);
            end
        end
        if (!advance_i) ptr_d = ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cvxif_copro_router.sv
// CV-X-IF issue/commit/result fan-out with per-ID ownership table and a registered result port.
module cvxif_copro_router
    import cvxif_router_pkg::*;
#(
    parameter int unsigned NUM_COPRO = 2,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_RS    = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           core_issue_valid_i,
    output logic                           core_issue_ready_o,
    input  logic [31:0]                    core_issue_instr_i,
    input  logic [ID_W-1:0]                core_issue_id_i,
    input  logic [NUM_RS*XLEN-1:0]         core_issue_rs_i,
    input  logic [NUM_RS-1:0]              core_issue_rs_valid_i,
    output logic                           core_issue_accept_o,
    output logic                           core_issue_writeback_o,
    input  logic                           core_commit_valid_i,
    input  logic [ID_W-1:0]                core_commit_id_i,
    input  logic                           core_commit_kill_i,
    output logic                           core_result_valid_o,
    input  logic                           core_result_ready_i,
    output logic [ID_W-1:0]                core_result_id_o,
    output logic [XLEN-1:0]                core_result_data_o,
    output logic [4:0]                     core_result_rd_o,
    output logic                           core_result_we_o,
    output logic                           core_result_exc_o,
    output logic [EXCCODE_W-1:0]           core_result_exccode_o,
    output logic [NUM_COPRO-1:0]           cp_issue_valid_o,
    input  logic [NUM_COPRO-1:0]           cp_issue_ready_i,
    input  logic [NUM_COPRO-1:0]           cp_issue_accept_i,
    input  logic [NUM_COPRO-1:0]           cp_issue_writeback_i,
    output logic [31:0]                    cp_issue_instr_o,
    output logic [ID_W-1:0]                cp_issue_id_o,
    output logic [NUM_RS*XLEN-1:0]         cp_issue_rs_o,
    output logic [NUM_RS-1:0]              cp_issue_rs_valid_o,
    output logic [NUM_COPRO-1:0]           cp_commit_valid_o,
    output logic [NUM_COPRO-1:0]           cp_commit_kill_o,
    output logic [ID_W-1:0]                cp_commit_id_o,
    input  logic [NUM_COPRO-1:0]           cp_result_valid_i,
    output logic [NUM_COPRO-1:0]           cp_result_ready_o,
    input  logic [NUM_COPRO*ID_W-1:0]      cp_result_id_i,
    input  logic [NUM_COPRO*XLEN-1:0]      cp_result_data_i,
    input  logic [NUM_COPRO*5-1:0]         cp_result_rd_i,
    input  logic [NUM_COPRO-1:0]           cp_result_we_i,
    input  logic [NUM_COPRO-1:0]           cp_result_exc_i,
    input  logic [NUM_COPRO*EXCCODE_W-1:0] cp_result_exccode_i,
    output logic                           err_multi_accept_o,
    output logic                           err_stray_o
);

    localparam int unsigned IDX_W  = idx_w(NUM_COPRO);
    localparam int unsigned NUM_ID = 2 ** ID_W;

    entry_t tbl_q [NUM_ID];
    entry_t tbl_d [NUM_ID];

    logic             id_free, accept, issue_fire;
    logic [IDX_W-1:0] iss_owner, gidx;
    logic             cm_hit, cm_stray;
    logic [NUM_COPRO-1:0] gnt;
    logic             out_free, grant_en, res_owner_ok, kill_race, res_load;
    logic [ID_W-1:0]  res_id;
    int unsigned      gsel;
    logic             err_multi_d, err_stray_d;

    logic                 out_valid_q, out_we_q, out_exc_q;
    logic [ID_W-1:0]      out_id_q;
    logic [XLEN-1:0]      out_data_q;
    logic [4:0]           out_rd_q;
    logic [EXCCODE_W-1:0] out_exccode_q;

    // Issue: broadcast payload, owner is the lowest accepting coprocessor.
    always_comb begin
        accept    = 1'b0;
        iss_owner = '0;
        for (int i = NUM_COPRO - 1; i >= 0; i--) begin
            if (cp_issue_accept_i[i]) begin
                accept    = 1'b1;
                iss_owner = IDX_W'(i);
            end
        end
    end

    assign id_free                = ~tbl_q[core_issue_id_i].valid;
    assign cp_issue_valid_o       = {NUM_COPRO{core_issue_valid_i & id_free}};
    assign core_issue_ready_o     = id_free & (&cp_issue_ready_i);
    assign core_issue_accept_o    = accept;
    assign core_issue_writeback_o = accept & cp_issue_writeback_i[iss_owner];
    assign issue_fire             = core_issue_valid_i & core_issue_ready_o & accept;
    assign cp_issue_instr_o       = core_issue_instr_i;
    assign cp_issue_id_o          = core_issue_id_i;
    assign cp_issue_rs_o          = core_issue_rs_i;
    assign cp_issue_rs_valid_o    = core_issue_rs_valid_i;

    // Commit: non-owners that also accepted are always told to kill.
    assign cm_hit         = core_commit_valid_i & tbl_q[core_commit_id_i].valid;
    assign cm_stray       = core_commit_valid_i & ~tbl_q[core_commit_id_i].valid;
    assign cp_commit_id_o = core_commit_id_i;

    always_comb begin
        cp_commit_valid_o = '0;
        cp_commit_kill_o  = '0;
        for (int i = 0; i < NUM_COPRO; i++) begin
            cp_commit_valid_o[i] = cm_hit & tbl_q[core_commit_id_i].mask[i];
            cp_commit_kill_o[i]  = cm_hit & tbl_q[core_commit_id_i].mask[i] &
                ((tbl_q[core_commit_id_i].owner == OWNER_W'(i)) ? core_commit_kill_i : 1'b1);
        end
    end

    // Result arbitration into the output register.
    assign out_free          = ~out_valid_q | core_result_ready_i;
    assign grant_en          = out_free & (|cp_result_valid_i);
    assign cp_result_ready_o = gnt & {NUM_COPRO{out_free}};

    rr_arbiter #(
        .NUM_REQ(NUM_COPRO)
    ) u_rr_arbiter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (cp_result_valid_i),
        .advance_i(grant_en),
        .gnt_o    (gnt)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_COPRO; i++) begin
            if (gnt[i]) gidx = IDX_W'(i);
        end
    end

    assign gsel         = 32'(gidx);
    assign res_id       = cp_result_id_i[gsel*ID_W +: ID_W];
    assign res_owner_ok = tbl_q[res_id].valid & (tbl_q[res_id].owner == OWNER_W'(gidx));
    assign kill_race    = cm_hit & core_commit_kill_i & (core_commit_id_i == res_id);
    assign res_load     = grant_en & res_owner_ok & ~kill_race;

    assign err_multi_d = issue_fire & ($countones(cp_issue_accept_i) > 1);
    assign err_stray_d = cm_stray | (grant_en & ~res_owner_ok & ~kill_race);

    // A result clearing the entry overrides a same-cycle non-kill commit.
    always_comb begin
        tbl_d = tbl_q;
        if (issue_fire) begin
            tbl_d[core_issue_id_i] = '{valid: 1'b1, owner: OWNER_W'(iss_owner),
                                       mask: MAX_COPRO'(cp_issue_accept_i),
                                       wb: cp_issue_writeback_i[iss_owner], committed: 1'b0};
        end
        if (cm_hit) begin
            if (core_commit_kill_i || !tbl_q[core_commit_id_i].wb) tbl_d[core_commit_id_i] = '0;
            else tbl_d[core_commit_id_i].committed = 1'b1;
        end
        if (res_load) tbl_d[res_id] = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ID; i++) tbl_q[i] <= '0;
            err_multi_accept_o <= 1'b0;
            err_stray_o        <= 1'b0;
            out_valid_q        <= 1'b0;
            out_id_q           <= '0;
            out_data_q         <= '0;
            out_rd_q           <= '0;
            out_we_q           <= 1'b0;
            out_exc_q          <= 1'b0;
            out_exccode_q      <= '0;
        end else begin
            tbl_q              <= tbl_d;
            err_multi_accept_o <= err_multi_d;
            err_stray_o        <= err_stray_d;
            if (res_load) begin
                out_valid_q   <= 1'b1;
                out_id_q      <= res_id;
                out_data_q    <= cp_result_data_i[gsel*XLEN +: XLEN];
                out_rd_q      <= cp_result_rd_i[gsel*5 +: 5];
                out_we_q      <= cp_result_we_i[gidx];
                out_exc_q     <= cp_result_exc_i[gidx];
                out_exccode_q <= cp_result_exccode_i[gsel*EXCCODE_W +: EXCCODE_W];
            end else if (core_result_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign core_result_valid_o   = out_valid_q;
    assign core_result_id_o      = out_id_q;
    assign core_result_data_o    = out_data_q;
    assign core_result_rd_o      = out_rd_q;
    assign core_result_we_o      = out_we_q;
    assign core_result_exc_o     = out_exc_q;
    assign core_result_exccode_o = out_exccode_q;

endmodule

// File: doc/cvxif_copro_router.md
Name: cvxif_copro_router

Overview:
CV-X-IF fan-out router between the cva6 core's coprocessor port and NUM_COPRO coprocessors (e.g. the vproc vector unit plus further accelerators). Covers the issue, commit and result channels. Keeps a per-transaction-ID ownership table, steers commits to owners, and round-robin arbitrates results into one registered result port. The memory and compressed channels are out of scope; the top level keeps routing those to a single coprocessor.

Parameters:
NUM_COPRO, 2, number of attached coprocessors (1..8)
ID_W, 3, transaction ID width (ariane_pkg::TRANS_ID_BITS)
XLEN, 32, register and result data width
NUM_RS, 2, source operands per issue
IDX_W, $clog2(NUM_COPRO) min 1, owner index width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
core_issue_valid_i  in  1  core issue request
core_issue_ready_o  out  1  issue handshake ready
core_issue_instr_i  in  32  instruction
core_issue_id_i  in  ID_W  transaction ID
core_issue_rs_i  in  NUM_RS*XLEN  operands
core_issue_rs_valid_i  in  NUM_RS  operand valids
core_issue_accept_o  out  1  any coprocessor accepted
core_issue_writeback_o  out  1  owner will write back
core_commit_valid_i  in  1  commit strobe
core_commit_id_i  in  ID_W  commit ID
core_commit_kill_i  in  1  kill flag
core_result_valid_o  out  1  result valid
core_result_ready_i  in  1  core result ready
core_result_id_o / data_o / rd_o / we_o / exc_o / exccode_o  out  ID_W / XLEN / 5 / 1 / 1 / 6  result fields
cp_issue_valid_o / ready_i / accept_i / writeback_i  out/in/in/in  NUM_COPRO each  per-coprocessor issue
cp_issue_instr_o, cp_issue_id_o, cp_issue_rs_o, cp_issue_rs_valid_o  out  shared  broadcast issue payload
cp_commit_valid_o / cp_commit_kill_o  out  NUM_COPRO each  per-coprocessor commit
cp_commit_id_o  out  ID_W  broadcast commit ID
cp_result_valid_i / cp_result_ready_o  in/out  NUM_COPRO each  per-coprocessor result
cp_result_id_i, data_i, rd_i, we_i, exc_i, exccode_i  in  NUM_COPRO-packed  result fields
err_multi_accept_o  out  1  pulse: more than one coprocessor accepted
err_stray_o  out  1  pulse: commit or result for an unowned ID

Behaviour:
- Reset: table entries invalid, core_result_valid_o=0, RR pointer=0, error outputs=0, all cp_*_valid_o=0.
- Table, 2**ID_W entries, each holds: valid, owner[IDX_W], accept_mask[NUM_COPRO], wb, committed.
- Issue (combinational pass-through):
  - cp_issue_valid_o[i] = core_issue_valid_i & ~table[id].valid.
  - core_issue_ready_o = ~table[id].valid & AND(cp_issue_ready_i). An ID collision stalls.
  - accept = OR(cp_issue_accept_i). owner = lowest accepting index. writeback_o = writeback of that owner.
  - On handshake with accept: entry is written valid with mask = accept vector. Popcount(mask)>1 pulses err_multi_accept_o for 1 cycle.
- Commit (combinational), only when table[id].valid:
  - cp_commit_valid_o[i] = mask[i].
  - Owner gets kill = core_commit_kill_i. Every non-owner in the mask gets kill = 1.
  - On commit to an invalid entry: nothing is forwarded and err_stray_o pulses.
  - Entry clears on commit when kill=1 or wb=0. Otherwise committed is set.
- Result arbitration:
  - Round-robin over cp_result_valid_i. The pointer advances past the grantee on each grant.
  - A grant happens when the output register is empty, or when it drains in the same cycle.
  - Granted coprocessor sees cp_result_ready_o=1 for exactly that cycle.
- Result acceptance:
  - If table[result id] is valid and the grantee is its owner, the result loads the output register and the entry clears.
  - Otherwise the result is popped and dropped, and err_stray_o pulses.
  - If a kill commit hits the same id in the same cycle, the kill wins and the result is dropped without a stray error.
- Output register holds its value stable until core_result_ready_i. Back-to-back throughput is 1 result/cycle. Latency from coprocessor valid to core valid is 1 cycle.
- Issue write and clear on the same entry cannot coincide, because issue stalls on a valid entry.
- Reset mid-transaction discards the table and the output register. Coprocessors must be reset together with the router.

Decomposition:
- cvxif_router_pkg: entry_t struct (valid, owner, mask, wb, committed), the IDX_W function, and exccode width constant 6.
- One sub-module, rr_arbiter (NUM_REQ, sync active-high reset): req vector in, one-hot grant out, advance input.

Test Plan:
- Single owner: NUM_COPRO=2, id=3 accepted only by cp1 with wb=1 -> commit id=3 kill=0 reaches only cp1. cp1 result data 0xDEADBEEF -> core sees id=3 one cycle later and the entry clears.
- Collision: re-issue id=3 while pending -> core_issue_ready_o=0 and cp_issue_valid_o=00 until the result drains. Then the issue proceeds.
- Double accept: cp0 and cp1 both accept id=5 -> err_multi_accept_o pulses once and owner=cp0. Commit kill=0 -> cp0 kill=0, cp1 kill=1.
- Fairness: cp0 and cp1 present results continuously with core_result_ready_i=1 -> grants alternate 0,1,0,1 with no bubbles.
- Backpressure: core_result_ready_i=0 for 4 cycles -> output held stable and both cp_result_ready_o=0. Release -> drains in order.
- Kill race: commit kill=1 for id=2 in the same cycle as cp0's result for id=2 -> result dropped, entry invalid, no err_stray_o.
